riscboy_ppu_span_fetch: RTL and testbench
=========================================

// Module: riscboy_ppu_span_fetch
//
// PURPOSE
// Upstream requestor for the PPU bus arbiter: converts one span command (start address, halfword count) into
// sequential halfword read requests on a single arbiter requestor port. Buffers returned data in a FIFO for the
// downstream pixel unpacker, tagging the final halfword of each span. Data phase has no backpressure, so issue
// is credit-limited: in-flight reads plus buffered data never exceed FIFO_DEPTH, and the FIFO never overflows.
//
// PARAMETERS
// W_ADDR      18  byte address width, matches arbiter
// W_DATA      16  bus data width, one halfword
// W_COUNT     9   span length field width, in halfwords
// FIFO_DEPTH  4   output FIFO entries, also the maximum outstanding reads
//
// PORTS
// clk           in   1        clock
// rst_n         in   1        async reset, active-low
// flush         in   1        abort current span, discard buffered and in-flight data
// cmd_vld       in   1        span command valid
// cmd_rdy       out  1        span command accepted when vld && rdy
// cmd_addr      in   W_ADDR   span start byte address; bit 0 ignored
// cmd_count     in   W_COUNT  span length in halfwords; 0 = empty span
// bus_aph_vld   out  1        read request valid to arbiter
// bus_aph_rdy   in   1        arbiter grant; transfer when vld && rdy
// bus_aph_size  out  2        constant 2'b01 (halfword)
// bus_aph_addr  out  W_ADDR   request byte address, bit 0 always 0
// bus_dph_vld   in   1        read data returned, in request order
// bus_dph_data  in   W_DATA   read data
// out_vld       out  1        buffered halfword available
// out_rdy       in   1        consumer pop
// out_data      out  W_DATA   halfword
// out_last      out  1        halfword is final of its span
// busy          out  1        state != IDLE
//
// BEHAVIOUR
// - Reset: state IDLE, all counters 0, FIFO empty. cmd_rdy=1, bus_aph_vld=0, out_vld=0, out_last=0, busy=0,
//   bus_aph_addr=0, out_data=0.
// - States: IDLE -> ISSUE on cmd accept (count!=0); count==0 is consumed with no state change and no output.
//   ISSUE -> WAIT when issue counter reaches 0. WAIT -> IDLE when response counter reaches 0.
//   Any state -> DRAIN on flush if in_flight!=0, else -> IDLE. DRAIN -> IDLE when in_flight==0.
// - cmd_rdy = (state==IDLE) && !flush. Next command may start while FIFO still holds the previous span's data.
// - On accept: addr <= {cmd_addr[W_ADDR-1:1],1'b0}; issue_rem <= cmd_count; resp_rem <= cmd_count.
// - bus_aph_vld = (state==ISSUE) && (in_flight + fifo_level < FIFO_DEPTH). Registered-state driven only, never
//   from bus_aph_rdy. First request is visible the cycle after cmd accept.
// - On aph handshake: addr += 2, modulo 2^W_ADDR (wraps silently); issue_rem--; in_flight++.
// - On bus_dph_vld: in_flight--. In ISSUE/WAIT, push {resp_rem==1, data} and decrement resp_rem.
//   In DRAIN, discard the data. out_vld is asserted the cycle after the push.
// - Same-cycle aph handshake and dph_vld: in_flight is unchanged. Same-cycle push and pop are both legal.
// - Flush: FIFO is cleared the same cycle and out_vld=0 on the next cycle. A request handshaked in the flush
//   cycle counts as in flight and its data is discarded. bus_aph_vld=0 from the next cycle. Flush overrides
//   cmd accept.
// - in_flight, fifo_level width $clog2(FIFO_DEPTH+1). issue_rem, resp_rem width W_COUNT.
// - Invariant (assert): in_flight + fifo_level <= FIFO_DEPTH. bus_dph_vld with in_flight==0 is illegal.
// - out_vld && !out_rdy: out_data and out_last are held stable.
//
// STRUCTURE
// - Shared package ppu_defs: bus size encodings (SIZE_HALF=2'b01) and state encoding localparams.
// - Sub-module: the codebase sync_fifo (DEPTH=FIFO_DEPTH, WIDTH=W_DATA+1, flush=flush), holding {last,data}.
// - Top: FSM, address/issue/response counters, in_flight counter, credit compare.
//
// TESTING
// 1. cmd addr=0x100 count=3, aph_rdy=1, dph 2 cycles later, out_rdy=1 -> aph addrs 0x100,0x102,0x104;
//    out_last only on the 3rd halfword; busy drops after the 3rd response.
// 2. FIFO_DEPTH=4, count=8, out_rdy=0 -> exactly 4 requests, then aph_vld=0. Pop 1 -> exactly 1 more request.
//    No overflow.
// 3. addr=0x3FFFE (W_ADDR=18), count=2 -> requests 0x3FFFE then 0x00000. Odd cmd_addr 0x101 -> first 0x100.
// 4. Flush with 2 in flight and 1 buffered -> out_vld=0 next cycle; both late responses discarded;
//    cmd_rdy returns only after in_flight==0.
// 5. count=0 -> cmd_rdy stays 1, no aph_vld, no out_vld. Back-to-back spans -> out_last delimits each span.
// 6. Random aph_rdy/out_rdy/dph latency -> data order matches a scoreboard; credit invariant assertion holds.

Source files
------------

// File: rtl/ppu_defs.sv
// Shared PPU definitions: bus transfer size encodings and span-fetch state encoding.
package ppu_defs;

  localparam logic [1:0] SIZE_HALF = 2'b01;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    DRAIN = ST_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; read data is the head entry, valid whenever not empty.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 17,
  localparam int unsigned W_LEVEL = $clog2(DEPTH + 1),
  localparam int unsigned W_PTR   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               pop,
  output logic [WIDTH-1:0]   rdata,
  output logic               empty,
  output logic [W_LEVEL-1:0] level
);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [W_PTR-1:0]   wptr_q, rptr_q;
  logic [W_LEVEL-1:0] level_q;
  logic               full_c, push_en_c, pop_en_c;

  function automatic logic [W_PTR-1:0] ptr_inc(input logic [W_PTR-1:0] p);
    return (p == W_PTR'(DEPTH - 1)) ? '0 : p + W_PTR'(1);
  endfunction

  assign empty     = (level_q == '0);
  assign full_c    = (level_q == W_LEVEL'(DEPTH));
  assign pop_en_c  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign push_en_c = push && (!full_c || pop_en_c);
  assign rdata     = mem_q[rptr_q];
  assign level     = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_en_c) wptr_q <= ptr_inc(wptr_q);
      if (pop_en_c)  rptr_q <= ptr_inc(rptr_q);
      level_q <= level_q + W_LEVEL'(push_en_c) - W_LEVEL'(pop_en_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_en_c && !flush) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/riscboy_ppu_span_fetch.sv
// PPU span fetcher: turns {addr, count} span commands into credit-limited halfword reads on one
// arbiter port and buffers the returned data, tagged with end-of-span, for the pixel unpacker.
module riscboy_ppu_span_fetch
  import ppu_defs::*;
#(
  parameter int unsigned W_ADDR     = 18,
  parameter int unsigned W_DATA     = 16,
  parameter int unsigned W_COUNT    = 9,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               cmd_vld,
  output logic               cmd_rdy,
  input  logic [W_ADDR-1:0]  cmd_addr,
  input  logic [W_COUNT-1:0] cmd_count,
  output logic               bus_aph_vld,
  input  logic               bus_aph_rdy,
  output logic [1:0]         bus_aph_size,
  output logic [W_ADDR-1:0]  bus_aph_addr,
  input  logic               bus_dph_vld,
  input  logic [W_DATA-1:0]  bus_dph_data,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [W_DATA-1:0]  out_data,
  output logic               out_last,
  output logic               busy
);

  localparam int unsigned W_LEVEL  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned W_CREDIT = W_LEVEL + 1;
  localparam int unsigned W_ENTRY  = W_DATA + 1;

  fetch_state_e       state_q, state_d;
  logic [W_ADDR-1:0]  addr_q, addr_d;
  logic [W_COUNT-1:0] issue_rem_q, issue_rem_d;
  logic [W_COUNT-1:0] resp_rem_q, resp_rem_d;
  logic [W_LEVEL-1:0] in_flight_q, in_flight_d;
  logic [W_LEVEL-1:0] fifo_level;
  logic [W_ENTRY-1:0] fifo_wdata, fifo_rdata;
  logic               fifo_empty;
  logic               fifo_push_c;
  logic               credit_ok_c;
  logic               cmd_fire_c, aph_fire_c;

  // Data phase cannot be stalled, so only issue while every in-flight read has a FIFO slot.
  assign credit_ok_c = (W_CREDIT'(in_flight_q) + W_CREDIT'(fifo_level)) < W_CREDIT'(FIFO_DEPTH);

  assign cmd_rdy      = (state_q == IDLE) && !flush;
  assign bus_aph_vld  = (state_q == ISSUE) && credit_ok_c;
  assign bus_aph_size = SIZE_HALF;
  assign bus_aph_addr = addr_q;
  assign busy         = (state_q != IDLE);
  assign cmd_fire_c   = cmd_vld && cmd_rdy;
  assign aph_fire_c   = bus_aph_vld && bus_aph_rdy;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_rem_d = issue_rem_q;
    resp_rem_d  = resp_rem_q;
    fifo_push_c = 1'b0;
    fifo_wdata  = {resp_rem_q == W_COUNT'(1), bus_dph_data};

    if (cmd_fire_c) begin
      addr_d      = cmd_addr & ~W_ADDR'(1);
      issue_rem_d = cmd_count;
      resp_rem_d  = cmd_count;
    end
    if (aph_fire_c) begin
      addr_d      = addr_q + W_ADDR'(2);
      issue_rem_d = issue_rem_q - W_COUNT'(1);
    end
    if (bus_dph_vld && ((state_q == ISSUE) || (state_q == WAIT))) begin
      fifo_push_c = 1'b1;
      resp_rem_d  = resp_rem_q - W_COUNT'(1);
    end
    in_flight_d = in_flight_q + W_LEVEL'(aph_fire_c) - W_LEVEL'(bus_dph_vld);

    case (state_q)
      IDLE:    if (cmd_fire_c && (cmd_count != '0)) state_d = ISSUE;
      ISSUE:   if (issue_rem_d == '0) state_d = (resp_rem_d == '0) ? IDLE : WAIT;
      WAIT:    if (resp_rem_d == '0) state_d = IDLE;
      DRAIN:   if (in_flight_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Reads already on the bus must still be absorbed before a new span may start.
    if (flush) state_d = (in_flight_d != '0) ? DRAIN : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_rem_q <= '0;
      resp_rem_q  <= '0;
      in_flight_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_rem_q <= issue_rem_d;
      resp_rem_q  <= resp_rem_d;
      in_flight_q <= in_flight_d;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (W_ENTRY)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (fifo_push_c),
    .wdata (fifo_wdata),
    .pop   (out_rdy),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_vld  = !fifo_empty;
  assign out_data = fifo_rdata[W_DATA-1:0];
  assign out_last = fifo_rdata[W_DATA];

  a_credit: assert property (@(posedge clk) disable iff (!rst_n)
    (W_CREDIT'(in_flight_q) + W_CREDIT'(fifo_level)) <= W_CREDIT'(FIFO_DEPTH));

  a_dph_legal: assert property (@(posedge clk) disable iff (!rst_n)
    bus_dph_vld |-> (in_flight_q != '0));

endmodule

// File: tb/tb_riscboy_ppu_span_fetch.sv
// Bench for riscboy_ppu_span_fetch: span-level reference model (request list, in-order responder,
// expected output queue) compared every cycle, plus a span table and directed corner sequences.
module tb_riscboy_ppu_span_fetch;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [17:0] cmd_addr;
  logic [8:0]  cmd_count;
  logic        bus_aph_vld;
  logic        bus_aph_rdy;
  logic [1:0]  bus_aph_size;
  logic [17:0] bus_aph_addr;
  logic        bus_dph_vld;
  logic [15:0] bus_dph_data;
  logic        out_vld;
  logic        out_rdy;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;

  always #5 clk = ~clk;

  riscboy_ppu_span_fetch #(
    .W_ADDR(18), .W_DATA(16), .W_COUNT(9), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_count(cmd_count),
    .bus_aph_vld(bus_aph_vld), .bus_aph_rdy(bus_aph_rdy), .bus_aph_size(bus_aph_size),
    .bus_aph_addr(bus_aph_addr), .bus_dph_vld(bus_dph_vld), .bus_dph_data(bus_dph_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  typedef struct { logic [17:0] addr; logic last; } req_t;
  typedef struct { logic [17:0] addr; logic last; int due; bit discard; } rsp_t;
  typedef struct { logic [15:0] data; logic last; } out_t;
  typedef struct {
    logic [17:0] addr; logic [8:0] count;
    logic [17:0] exp_first; logic [17:0] exp_final; int exp_nreq;
  } vec_t;

  req_t        exp_req[$];
  rsp_t        rsp_q[$];
  out_t        exp_out[$];
  logic [17:0] aph_log[$];
  logic        last_log[$];

  int total = 0, bad = 0, cyc = 0, last_due = -1, n_req = 0;
  int lat_min = 1, lat_max = 1, aph_pct = 100, out_pct = 100, flush_permille = 0;
  bit force_flush = 1'b0, cmd_acc = 1'b0;

  function automatic logic [15:0] memf(input logic [17:0] a);
    return {a[8:1], a[16:9]} ^ {15'h0, a[17]} ^ 16'hC35A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, compare against the model before the edge, advance the model after it.
  task automatic cycle();
    bit dph, aph_hs, out_hs, cmd_hs, fl, idle, exp_aph;
    int c, lat, due;
    rsp_t r;
    req_t q;
    logic [17:0] base;
    dph = (rsp_q.size() != 0) && (rsp_q[0].due <= cyc);
    bus_dph_vld  = dph;
    bus_dph_data = dph ? memf(rsp_q[0].addr) : 16'h0;
    bus_aph_rdy  = ($urandom_range(99) < aph_pct);
    out_rdy      = ($urandom_range(99) < out_pct);
    flush        = force_flush || ($urandom_range(999) < flush_permille);
    #1;
    idle    = (exp_req.size() == 0) && (rsp_q.size() == 0);
    exp_aph = (exp_req.size() != 0) && ((rsp_q.size() + exp_out.size()) < DEPTH);
    chk("aph_vld", 32'(bus_aph_vld), 32'(exp_aph));
    chk("cmd_rdy", 32'(cmd_rdy), 32'(idle && !flush));
    chk("busy", 32'(busy), 32'(!idle));
    chk("out_vld", 32'(out_vld), 32'(exp_out.size() != 0));
    if (out_vld && exp_out.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(exp_out[0].data));
      chk("out_last", 32'(out_last), 32'(exp_out[0].last));
    end
    aph_hs = bus_aph_vld && bus_aph_rdy;
    out_hs = out_vld && out_rdy;
    cmd_hs = cmd_vld && idle && !flush;
    fl     = flush;
    c      = cyc;
    if (aph_hs) begin
      n_req++;
      aph_log.push_back(bus_aph_addr);
      if (exp_req.size() == 0) chk("aph_unexpected", 32'(1), 32'(0));
      else chk("aph_addr", 32'(bus_aph_addr), 32'(exp_req[0].addr));
    end
    if (out_hs) last_log.push_back(out_last);
    @(posedge clk);
    cyc++;
    if (out_hs && exp_out.size() != 0) void'(exp_out.pop_front());
    if (dph) begin
      r = rsp_q.pop_front();
      if (!r.discard) exp_out.push_back('{data: memf(r.addr), last: r.last});
    end
    if (aph_hs && exp_req.size() != 0) begin
      q   = exp_req.pop_front();
      lat = $urandom_range(lat_max, lat_min);
      due = (c + lat > last_due + 1) ? c + lat : last_due + 1;
      last_due = due;
      rsp_q.push_back('{addr: q.addr, last: q.last, due: due, discard: 1'b0});
    end
    if (fl) begin
      foreach (rsp_q[i]) rsp_q[i].discard = 1'b1;
      exp_out.delete();
      exp_req.delete();
    end
    if (cmd_hs) begin
      base = {cmd_addr[17:1], 1'b0};
      for (int i = 0; i < int'(cmd_count); i++)
        exp_req.push_back('{addr: base + 18'(2 * i), last: (i == int'(cmd_count) - 1)});
    end
    cmd_acc = cmd_hs;
    #1;
  endtask

  task automatic issue_cmd(input logic [17:0] a, input logic [8:0] n);
    int k;
    cmd_vld = 1'b1; cmd_addr = a; cmd_count = n;
    k = 0;
    cmd_acc = 1'b0;
    while (!cmd_acc && k < 300) begin cycle(); k++; end
    if (!cmd_acc) chk("cmd_accept_timeout", 32'(1), 32'(0));
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit need_empty);
    int k;
    k = 0;
    while (!((exp_req.size() == 0) && (rsp_q.size() == 0) && (!need_empty || exp_out.size() == 0))
           && k < budget) begin
      cycle(); k++;
    end
    if (k >= budget) chk("idle_timeout", 32'(1), 32'(0));
  endtask

  vec_t vecs[8];
  int   nlast;

  initial begin
    vecs[0] = '{18'h00100, 9'd3, 18'h00100, 18'h00104, 3};
    vecs[1] = '{18'h00101, 9'd2, 18'h00100, 18'h00102, 2};
    vecs[2] = '{18'h3FFFE, 9'd2, 18'h3FFFE, 18'h00000, 2};
    vecs[3] = '{18'h00040, 9'd0, 18'h00000, 18'h00000, 0};
    vecs[4] = '{18'h3FFFB, 9'd4, 18'h3FFFA, 18'h00000, 4};
    vecs[5] = '{18'h01234, 9'd1, 18'h01234, 18'h01234, 1};
    vecs[6] = '{18'h00000, 9'd0, 18'h00000, 18'h00000, 0};
    vecs[7] = '{18'h0AAAB, 9'd5, 18'h0AAAA, 18'h0AAB2, 5};

    rst_n = 1'b0; flush = 1'b0; cmd_vld = 1'b0; cmd_addr = '0; cmd_count = '0;
    bus_aph_rdy = 1'b0; bus_dph_vld = 1'b0; bus_dph_data = '0; out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'(1));
    chk("rst_aph_vld", 32'(bus_aph_vld), 32'(0));
    chk("rst_out_vld", 32'(out_vld), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_aph_addr", 32'(bus_aph_addr), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("aph_size", 32'(bus_aph_size), 32'(2'b01));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic span, fixed 2-cycle data latency.
    lat_min = 2; lat_max = 2; aph_pct = 100; out_pct = 100;
    aph_log.delete(); last_log.delete();
    issue_cmd(18'h00100, 9'd3);
    wait_idle(60, 1'b1);
    chk("t1_nreq", 32'(aph_log.size()), 32'(3));
    chk("t1_addr0", 32'(aph_log[0]), 32'h100);
    chk("t1_addr1", 32'(aph_log[1]), 32'h102);
    chk("t1_addr2", 32'(aph_log[2]), 32'h104);
    chk("t1_npop", 32'(last_log.size()), 32'(3));
    chk("t1_last0", 32'(last_log[0]), 32'(0));
    chk("t1_last1", 32'(last_log[1]), 32'(0));
    chk("t1_last2", 32'(last_log[2]), 32'(1));
    chk("t1_busy", 32'(busy), 32'(0));

    // Credit limit with a stalled consumer.
    lat_min = 1; lat_max = 3; out_pct = 0; n_req = 0;
    issue_cmd(18'h00200, 9'd8);
    repeat (20) cycle();
    chk("t2_credit_stop", 32'(n_req), 32'(4));
    chk("t2_aph_idle", 32'(bus_aph_vld), 32'(0));
    out_pct = 100; cycle(); out_pct = 0;
    repeat (20) cycle();
    chk("t2_one_more", 32'(n_req), 32'(5));
    out_pct = 100;
    wait_idle(200, 1'b1);

    // Flush with two reads in flight and one halfword buffered.
    lat_min = 3; lat_max = 3; out_pct = 0; n_req = 0;
    issue_cmd(18'h00300, 9'd8);
    for (int k = 0; k < 30 && n_req < 3; k++) cycle();
    chk("t4_issued3", 32'(n_req), 32'(3));
    aph_pct = 0;
    for (int k = 0; k < 20 && !(rsp_q.size() == 2 && exp_out.size() == 1); k++) cycle();
    chk("t4_setup", 32'(rsp_q.size() == 2 && exp_out.size() == 1), 32'(1));
    force_flush = 1'b1; cycle(); force_flush = 1'b0;
    chk("t4_out_vld", 32'(out_vld), 32'(0));
    chk("t4_cmd_rdy", 32'(cmd_rdy), 32'(0));
    chk("t4_busy", 32'(busy), 32'(1));
    wait_idle(50, 1'b0);
    chk("t4_drained_out", 32'(out_vld), 32'(0));
    chk("t4_cmd_rdy_back", 32'(cmd_rdy), 32'(1));
    aph_pct = 100; out_pct = 100;

    // Span table, back-to-back with random handshakes.
    lat_min = 1; lat_max = 4; aph_pct = 70; out_pct = 70;
    last_log.delete();
    foreach (vecs[v]) begin
      aph_log.delete(); n_req = 0;
      issue_cmd(vecs[v].addr, vecs[v].count);
      if (vecs[v].exp_nreq == 0) chk("tbl_empty_busy", 32'(busy), 32'(0));
      wait_idle(300, 1'b0);
      chk("tbl_nreq", 32'(n_req), 32'(vecs[v].exp_nreq));
      if (vecs[v].exp_nreq > 0) begin
        chk("tbl_first", 32'(aph_log[0]), 32'(vecs[v].exp_first));
        chk("tbl_final", 32'(aph_log[aph_log.size() - 1]), 32'(vecs[v].exp_final));
      end
    end
    out_pct = 100;
    wait_idle(300, 1'b1);
    nlast = 0;
    foreach (last_log[i]) if (last_log[i]) nlast++;
    chk("tbl_span_lasts", 32'(nlast), 32'(6));

    // Random traffic with occasional flushes.
    lat_min = 1; lat_max = 5; aph_pct = 60; out_pct = 60; flush_permille = 15;
    for (int k = 0; k < 1500; k++) begin
      if (!cmd_vld && $urandom_range(3) == 0) begin
        cmd_vld = 1'b1; cmd_addr = 18'($urandom); cmd_count = 9'($urandom_range(10));
      end
      cycle();
      if (cmd_acc) cmd_vld = 1'b0;
    end
    cmd_vld = 1'b0; flush_permille = 0; aph_pct = 100; out_pct = 100;
    wait_idle(500, 1'b1);
    cycle();
    chk("end_busy", 32'(busy), 32'(0));
    chk("end_out_vld", 32'(out_vld), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
